// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0,x0,0
  localparam int          CLOCK_PERIOD = 10;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer between memory responses and decode.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         clear,
  input  fetch_entry_t                 din,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int            CW   = $clog2(DEPTH + 1);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign do_push = push && (count != FULL);
  assign do_pop  = pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= bump(wr_ptr);
      end
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32i fetch stage: PC generation, req/gnt issue, in-order response
// buffering, and redirect handling with wrong-path response discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 3,
  parameter int          MAX_INFLIGHT = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        Stall_D,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  output logic        IMEM_Req,
  output logic [31:0] IMEM_Addr,
  input  logic        IMEM_Gnt,
  input  logic        IMEM_RValid,
  input  logic [31:0] IMEM_RData,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC_Plus_4_D,
  output logic        Valid_D
);

  // Headroom above MAX_INFLIGHT: old-stream requests still count as
  // in flight while a fresh stream is being issued after a redirect.
  localparam int CNT_W = $clog2(2 * MAX_INFLIGHT + 1);
  localparam int FC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SUM_W = ((CNT_W > FC_W) ? CNT_W : FC_W) + 1;

  logic [31:0]      pc_f, resp_pc, redirect_target;
  logic [CNT_W-1:0] inflight, discard;
  logic [FC_W-1:0]  fifo_count;
  logic [SUM_W-1:0] occupancy;
  fetch_entry_t     head, push_entry;
  logic             rsp, hs, push, pop;

  assign redirect_target = Redirect_PC & ~32'h3;

  // Slots already promised: buffered entries plus live (non-discarded) requests.
  assign occupancy = SUM_W'(fifo_count) + SUM_W'(inflight) - SUM_W'(discard);

  assign IMEM_Req  = RSTN && !Redirect_En && (occupancy < SUM_W'(FIFO_DEPTH));
  assign IMEM_Addr = pc_f;
  assign hs        = IMEM_Req && IMEM_Gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp  = IMEM_RValid && (inflight != '0);
  assign push = rsp && (discard == '0) && !Redirect_En;
  assign pop  = Valid_D && !Stall_D && !Redirect_En;

  assign push_entry = '{instr: IMEM_RData, pc: resp_pc};

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_f     <= RESET_VECTOR;
      resp_pc  <= RESET_VECTOR;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight + CNT_W'(hs) - CNT_W'(rsp);
      if (Redirect_En) begin
        pc_f    <= redirect_target;
        resp_pc <= redirect_target;
        discard <= inflight - CNT_W'(rsp);
      end else begin
        if (hs) pc_f <= pc_f + 32'd4;
        if (rsp && (discard != '0)) discard <= discard - 1'b1;
        if (push) resp_pc <= resp_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTN),
    .push  (push),
    .pop   (pop),
    .clear (Redirect_En),
    .din   (push_entry),
    .head  (head),
    .count (fifo_count)
  );

  assign Valid_D     = (fifo_count != '0);
  assign Instr_D     = Valid_D ? head.instr : NOP_INSTR;
  assign PC_D        = Valid_D ? head.pc : 32'h0;
  assign PC_Plus_4_D = PC_D + 32'd4;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the RV32i pipeline, directly upstream of decode and the control unit.
- Generates the PC and issues requests to instruction memory over a req/gnt + rvalid handshake.
- Buffers returned instructions in a small in-order FIFO and presents them with their PC to decode.
- Handles stalls from decode and redirects (taken branch/jump) from execute, discarding wrong-path in-flight responses.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC of the first fetch after reset.
FIFO_DEPTH, 3, instruction buffer entries; 3 sustains 1 instr/cycle with 1-cycle memory latency.
MAX_INFLIGHT, 3, counter sizing bound for outstanding requests; must be >= FIFO_DEPTH.

Ports:
CLK  in  1  clock, all state on rising edge.
RSTN  in  1  reset; asynchronous assert, active-low.
Stall_D  in  1  decode cannot accept this cycle.
Redirect_En  in  1  execute redirect (taken branch/jump).
Redirect_PC  in  32  redirect target; bits [1:0] forced to 0.
IMEM_Req  out  1  fetch request valid.
IMEM_Addr  out  32  fetch address (current PC_F).
IMEM_Gnt  in  1  memory accepts request this cycle.
IMEM_RValid  in  1  response valid; responses return in order.
IMEM_RData  in  32  response instruction word.
Instr_D  out  32  instruction to decode; NOP_INSTR when Valid_D=0.
PC_D  out  32  PC of Instr_D.
PC_Plus_4_D  out  32  PC_D + 4, modulo 2^32.
Valid_D  out  1  Instr_D is a real instruction.

Behaviour:
- Reset (RSTN=0, async):
  - PC_F=RESET_VECTOR; FIFO empty; inflight=0; discard=0.
  - Outputs during reset: IMEM_Req=0, Valid_D=0, Instr_D=NOP_INSTR, PC_D=0, PC_Plus_4_D=4.
- First IMEM_Req is asserted in the first cycle after reset release.
- Issue rule:
  - IMEM_Req = !Redirect_En && (fifo_count + (inflight - discard) < FIFO_DEPTH), using registered counts only.
  - IMEM_Addr = PC_F.
  - On handshake (IMEM_Req && IMEM_Gnt): PC_F += 4 (32-bit wrap), inflight++.
- Response:
  - On IMEM_RValid: inflight--.
  - If discard>0: data dropped, discard--.
  - Otherwise: push {IMEM_RData, pc}; the pc is taken from a response-PC register that starts at the stream base and advances by 4 per accepted response.
  - RValid with inflight==0 is ignored (protocol error; bench asserts it never occurs).
- Output:
  - FIFO head is driven combinationally from registered storage; Valid_D = fifo_count != 0.
  - Pop when Valid_D && !Stall_D.
  - Latency: issue at cycle N, RValid at N+1, Valid_D at N+2.
  - Steady-state throughput is 1 instr/cycle with gnt=1 and 1-cycle memory.
- Simultaneous push and pop on the same cycle: count unchanged. A full FIFO never receives a push; this is guaranteed by the issue rule.
- Redirect (Redirect_En=1), next edge:
  - PC_F = response-PC = {Redirect_PC[31:2],2'b00}.
  - FIFO cleared.
  - discard = inflight - IMEM_RValid, i.e. all old-stream requests still outstanding after this cycle.
  - No issue in the redirect cycle.
  - Redirect overrides Stall_D and any same-cycle push or pop.
  - Valid_D=0 in the cycle after the redirect.
- A redirect while already discarding: discard recomputed per the same rule, with inflight covering both old streams.
- Stall_D held: FIFO fills to FIFO_DEPTH - inflight_live, issue stops, PC_F holds, no instruction lost or duplicated.
- Reset mid-operation: all state cleared immediately. Responses that arrive after reset see inflight=0 and are ignored.

Decomposition:
- Package definitions gains:
  - NOP_INSTR = 32'h0000_0013 (addi x0,x0,0).
  - typedef fetch_entry_t = struct {instr[31:0], pc[31:0]}.
  - CLOCK_PERIOD is reused by the bench.
- Sub-module fetch_fifo: sync FIFO of fetch_entry_t, parameter DEPTH, with push, pop, clear (clear has priority), count, head, and async active-low reset.
- fetch_unit holds PC_F, response-PC, the inflight/discard counters, and issue logic.

Test Plan:
- Reset release, gnt=1, 1-cycle memory returning addr-tagged words → IMEM_Addr 0,4,8,… one per cycle; Valid_D first high 2 cycles after first req; PC_D 0,4,8 consecutive, PC_Plus_4_D 4,8,12.
- Stall_D=1 for 6 cycles from PC_D=8 → FIFO holds 3 entries (8,C,10); IMEM_Req low; on release PC_D sequence 8,C,10,14 with no gap or duplicate.
- Redirect_En=1, Redirect_PC=0x100 while 2 requests in flight (0x14,0x18) → those two responses dropped; next IMEM_Addr=0x100; next Valid_D shows PC_D=0x100.
- Redirect_PC=0x203 → fetch address 0x200; second redirect to 0x40 one cycle after first → only 0x40 stream ever reaches decode.
- IMEM_Gnt toggling 1,0,0,1 with 3-cycle response latency → in-order PCs, inflight never exceeds FIFO_DEPTH, Instr_D=0x00000013 whenever Valid_D=0.
- RSTN pulsed low mid-stream with a response arriving in the next cycle → Valid_D=0 and IMEM_Req=0 immediately; late response ignored; fetch restarts at RESET_VECTOR.
